// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer beside the CSR file: arbitrates exceptions,
// MRET and pending interrupts, updates trap CSRs and redirects the core PC.
module trap_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic            meip_async,
    input  logic            mtip,
    input  logic            msip,
    input  logic            boundary,
    input  logic [XLEN-1:0] boundary_pc,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    output logic            exc_ack,
    output logic            mret_ack,
    output logic            mstatus_we,
    output logic [XLEN-1:0] mstatus_wdata,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mbadaddr,
    output logic [XLEN-1:0] mip,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_MRET,
        S_REDIRECT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   meip_sync;
    logic [XLEN-1:0]        mip_q, mip_d;
    logic [XLEN-1:0]        mepc_q, mepc_d;
    logic [XLEN-1:0]        mcause_q, mcause_d;
    logic [XLEN-1:0]        mbad_q, mbad_d;
    logic [XLEN-1:0]        rpc_q, rpc_d;
    logic                   is_exc_q, is_exc_d;

    logic [XLEN-1:0]        irq_en;
    logic                   irq_any;
    logic [3:0]             irq_code;
    logic [XLEN-1:0]        vec_base;

    assign meip_sync = sync_q[SYNC_STAGES-1];
    assign vec_base  = {mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        mip_d     = '0;
        mip_d[11] = meip_sync;
        mip_d[7]  = mtip;
        mip_d[3]  = msip;
    end

    // Eligibility uses the registered mip so it matches what the CSR file reports.
    always_comb begin
        irq_en   = mstatus[3] ? (mie & mip_q) : '0;
        irq_any  = irq_en[11] | irq_en[3] | irq_en[7];
        irq_code = 4'd0;
        if (irq_en[11])     irq_code = 4'd11;
        else if (irq_en[3]) irq_code = 4'd3;
        else if (irq_en[7]) irq_code = 4'd7;
    end

    always_comb begin
        state_d       = state_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mbad_d        = mbad_q;
        rpc_d         = rpc_q;
        is_exc_d      = is_exc_q;
        exc_ack       = 1'b0;
        mret_ack      = 1'b0;
        mstatus_we    = 1'b0;
        mstatus_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    mepc_d   = {exc_pc[XLEN-1:2], 2'b00};
                    mcause_d = {{(XLEN-5){1'b0}}, exc_cause};
                    mbad_d   = exc_tval;
                    is_exc_d = 1'b1;
                    state_d  = S_SAVE;
                end else if (mret_valid) begin
                    state_d = S_MRET;
                end else if (boundary && irq_any) begin
                    mepc_d   = {boundary_pc[XLEN-1:2], 2'b00};
                    mcause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code};
                    mbad_d   = '0;
                    is_exc_d = 1'b0;
                    state_d  = S_SAVE;
                end
            end
            S_SAVE: begin
                mstatus_we        = 1'b1;
                mstatus_wdata     = mstatus;
                mstatus_wdata[7]  = mstatus[3];
                mstatus_wdata[3]  = 1'b0;
                mstatus_wdata[12:11] = 2'b11;
                exc_ack           = is_exc_q;
                // Vectored only for interrupts in mode 1; the cause bit shifts out.
                if (mtvec[1:0] == 2'b01 && mcause_q[XLEN-1])
                    rpc_d = vec_base + (mcause_q << 2);
                else
                    rpc_d = vec_base;
                state_d = S_REDIRECT;
            end
            S_MRET: begin
                mstatus_we        = 1'b1;
                mret_ack          = 1'b1;
                mstatus_wdata     = mstatus;
                mstatus_wdata[3]  = mstatus[7];
                mstatus_wdata[7]  = 1'b1;
                mstatus_wdata[12:11] = 2'b11;
                rpc_d             = mepc_q;
                state_d           = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            mip_q    <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
            mbad_q   <= '0;
            rpc_q    <= '0;
            is_exc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q[0] <= meip_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            mip_q    <= mip_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mbad_q   <= mbad_d;
            rpc_q    <= rpc_d;
            is_exc_q <= is_exc_d;
        end
    end

    assign mepc           = mepc_q;
    assign mcause         = mcause_q;
    assign mbadaddr       = mbad_q;
    assign mip            = mip_q;
    assign redirect_pc    = rpc_q;
    assign redirect_valid = (state_q == S_REDIRECT);
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected trap records are queued at stimulus time
// and retired by a monitor on the mstatus write and the redirect handshake.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mstatus, mie, mtvec;
    logic        meip_async, mtip, msip, boundary;
    logic [31:0] boundary_pc;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        mret_valid;
    logic        exc_ack, mret_ack, mstatus_we;
    logic [31:0] mstatus_wdata, mepc, mcause, mbadaddr, mip;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    trap_ctrl #(.XLEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .mstatus(mstatus), .mie(mie), .mtvec(mtvec),
        .meip_async(meip_async), .mtip(mtip), .msip(msip), .boundary(boundary),
        .boundary_pc(boundary_pc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
        .exc_ack(exc_ack), .mret_ack(mret_ack), .mstatus_we(mstatus_we),
        .mstatus_wdata(mstatus_wdata), .mepc(mepc), .mcause(mcause),
        .mbadaddr(mbadaddr), .mip(mip), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rpc, epc, cause, bad, wdata;
        bit          is_exc, is_mret;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ms_trap(input logic [31:0] ms);
        logic [31:0] r;
        r = ms; r[7] = ms[3]; r[3] = 1'b0; r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] ms_mret(input logic [31:0] ms);
        logic [31:0] r;
        r = ms; r[3] = ms[7]; r[7] = 1'b1; r[12:11] = 2'b11;
        return r;
    endfunction

    task automatic push(input logic [31:0] rpc, input logic [31:0] epc, input logic [31:0] cause,
                        input logic [31:0] bad, input logic [31:0] wdata, input bit ex, input bit mr);
        exp_t e;
        e.rpc = rpc; e.epc = epc; e.cause = cause; e.bad = bad; e.wdata = wdata;
        e.is_exc = ex; e.is_mret = mr;
        sb.push_back(e);
    endtask

    // which: 0 = exc_ack, 1 = mret_ack, 2 = busy high, 3 = busy low
    task automatic wait_sig(input int which, input string tag);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((which == 0 && exc_ack) || (which == 1 && mret_ack) ||
                (which == 2 && busy) || (which == 3 && !busy)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(tag, 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            if (mstatus_we) begin
                if (sb.size() == 0) check("we_unexpected", 32'd1, 32'd0);
                else begin
                    check("wdata", mstatus_wdata, sb[0].wdata);
                    check("exc_ack", {31'd0, exc_ack}, {31'd0, sb[0].is_exc});
                    check("mret_ack", {31'd0, mret_ack}, {31'd0, sb[0].is_mret});
                end
            end else begin
                check("wdata_idle", mstatus_wdata, 32'd0);
                if (exc_ack || mret_ack) check("ack_without_we", 32'd1, 32'd0);
            end
            if (redirect_valid && redirect_ready) begin
                if (sb.size() == 0) check("redirect_unexpected", 32'd1, 32'd0);
                else begin
                    check("redirect_pc", redirect_pc, sb[0].rpc);
                    check("mepc", mepc, sb[0].epc);
                    check("mcause", mcause, sb[0].cause);
                    check("mbadaddr", mbadaddr, sb[0].bad);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b1; mstatus = '0; mie = '0; mtvec = '0;
        meip_async = 0; mtip = 0; msip = 0; boundary = 0; boundary_pc = '0;
        exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_tval = '0; mret_valid = 0;
        redirect_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_mepc", mepc, 32'd0);
        check("rst_mcause", mcause, 32'd0);
        check("rst_mip", mip, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        @(posedge clk) #1 resetn = 1'b0;

        // Exception with explicit latency checks
        @(posedge clk) #1;
        mtvec = 32'h100; mstatus = 32'h08;
        push(32'h100, 32'h1004, 32'd2, 32'hDEAD_BEEF, ms_trap(32'h08), 1, 0);
        exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h1006; exc_tval = 32'hDEAD_BEEF;
        @(negedge clk);
        check("exc_lat_busy_early", {31'd0, exc_ack}, 32'd0);
        @(negedge clk);
        check("exc_n1_ack", {31'd0, exc_ack}, 32'd1);
        check("exc_n1_we", {31'd0, mstatus_we}, 32'd1);
        check("exc_n1_wdata", mstatus_wdata, 32'h1880);
        @(posedge clk) #1 exc_valid = 0;
        @(negedge clk);
        check("exc_n2_rv", {31'd0, redirect_valid}, 32'd1);
        check("exc_n2_rpc", redirect_pc, 32'h100);
        wait_sig(3, "exc_idle_timeout");

        // MRET back to the saved mepc
        @(posedge clk) #1;
        mstatus = 32'h1880;
        push(32'h1004, 32'h1004, 32'd2, 32'hDEAD_BEEF, ms_mret(32'h1880), 0, 1);
        mret_valid = 1;
        wait_sig(1, "mret_ack_timeout");
        check("mret_wdata", mstatus_wdata, 32'h1888);
        @(posedge clk) #1 mret_valid = 0;
        wait_sig(3, "mret_idle_timeout");

        // Vectored timer interrupt
        @(posedge clk) #1;
        mstatus = 32'h08; mtvec = 32'h201; mie = 32'h80; boundary_pc = 32'h400;
        push(32'h21C, 32'h400, 32'h8000_0007, 32'd0, ms_trap(32'h08), 0, 0);
        mtip = 1; boundary = 1;
        wait_sig(2, "timer_busy_timeout");
        @(posedge clk) #1 mtip = 0; boundary = 0;
        wait_sig(3, "timer_idle_timeout");

        // Masking by mstatus.MIE, then priority among all three
        @(posedge clk) #1;
        mstatus = 32'h00; mie = 32'h888; mtvec = 32'h100; boundary_pc = 32'h800;
        meip_async = 1; mtip = 1; msip = 1; boundary = 1;
        repeat (6) @(negedge clk);
        check("mask_mip", mip, 32'h888);
        check("mask_busy", {31'd0, busy}, 32'd0);
        @(posedge clk) #1;
        push(32'h100, 32'h800, 32'h8000_000B, 32'd0, ms_trap(32'h08), 0, 0);
        mstatus = 32'h08;
        wait_sig(2, "prio_busy_timeout");
        @(posedge clk) #1 meip_async = 0; mtip = 0; msip = 0; boundary = 0;
        wait_sig(3, "prio_idle_timeout");
        repeat (4) @(negedge clk);
        check("mip_cleared", mip, 32'd0);

        // Simultaneous exception + MRET under backpressure
        @(posedge clk) #1;
        redirect_ready = 0; mstatus = 32'h08; mtvec = 32'h100;
        push(32'h100, 32'h2000, 32'd5, 32'h1234, ms_trap(32'h08), 1, 0);
        push(32'h2000, 32'h2000, 32'd5, 32'h1234, ms_mret(32'h08), 0, 1);
        exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h2002; exc_tval = 32'h1234; mret_valid = 1;
        wait_sig(0, "bp_ack_timeout");
        check("bp_no_mret_ack", {31'd0, mret_ack}, 32'd0);
        @(posedge clk) #1 exc_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rv_hold", {31'd0, redirect_valid}, 32'd1);
            check("bp_busy_hold", {31'd0, busy}, 32'd1);
            check("bp_rpc_stable", redirect_pc, 32'h100);
        end
        @(posedge clk) #1 redirect_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_between", {31'd0, busy}, 32'd0);
        check("bp_mret_not_yet", {31'd0, mret_ack}, 32'd0);
        @(negedge clk);
        check("bp_mret_taken", {31'd0, mret_ack}, 32'd1);
        @(posedge clk) #1 mret_valid = 0;
        wait_sig(3, "bp_idle_timeout");

        // Reset while redirect is pending
        @(posedge clk) #1;
        redirect_ready = 0; mie = 32'd0; mtip = 1;
        push(32'h100, 32'h3000, 32'd1, 32'h55, ms_trap(32'h08), 1, 0);
        exc_valid = 1; exc_cause = 5'd1; exc_pc = 32'h3000; exc_tval = 32'h55;
        wait_sig(0, "rst_ack_timeout");
        @(posedge clk) #1 exc_valid = 0;
        @(negedge clk);
        check("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
        check("pre_rst_mip", mip, 32'h80);
        #2 resetn = 1'b1;
        #1;
        check("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_mepc", mepc, 32'd0);
        check("rst_mid_mip", mip, 32'd0);
        sb.delete();
        @(posedge clk) #1 resetn = 1'b0; mtip = 0; redirect_ready = 1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap/interrupt sequencer that sits directly beside the CSR file. It consumes mstatus, mie and mtvec from the CSR file and produces mepc, mbadaddr, mcause, mip and the mstatus write-back into it. It takes synchronous exceptions and MRET from the core, arbitrates them against pending interrupts, and redirects the core's PC through a valid/ready handshake.

Parameters:
XLEN, 32, data/address width
SYNC_STAGES, 2, synchronizer depth for the external interrupt input meip_async

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  reset, asynchronous, active-high (asserted = 1 clears all state)
mstatus  in  XLEN  current mstatus from CSR file; bit3 MIE, bit7 MPIE
mie  in  XLEN  interrupt enable CSR
mtvec  in  XLEN  trap vector; [1:0] mode, [31:2] base
meip_async  in  1  external interrupt, asynchronous level
mtip  in  1  timer interrupt level, synchronous to clk
msip  in  1  software interrupt level, synchronous to clk
boundary  in  1  core is at an instruction boundary; boundary_pc is valid
boundary_pc  in  XLEN  PC of the next instruction to execute
exc_valid  in  1  synchronous exception request, held until exc_ack
exc_cause  in  5  exception code
exc_pc  in  XLEN  PC of the faulting instruction
exc_tval  in  XLEN  faulting address/value
mret_valid  in  1  MRET request, held until mret_ack
exc_ack  out  1  one-cycle pulse: exception accepted
mret_ack  out  1  one-cycle pulse: MRET accepted
mstatus_we  out  1  one-cycle write strobe for mstatus
mstatus_wdata  out  XLEN  new mstatus value
mepc  out  XLEN  trap PC to CSR file
mcause  out  XLEN  trap cause to CSR file
mbadaddr  out  XLEN  trap value to CSR file
mip  out  XLEN  pending interrupts: bit11 MEIP, bit7 MTIP, bit3 MSIP, all other bits 0
redirect_valid  out  1  new PC available
redirect_pc  out  XLEN  target PC
redirect_ready  in  1  core accepts the redirect
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, synchronizer flops 0. All outputs are 0: mepc, mcause, mbadaddr, mip, redirect_pc, mstatus_wdata, and all strobes. Reset applies immediately from any state and discards any in-flight trap.
- mip is registered every cycle: {meip_sync, mtip, msip} at bits 11/7/3. meip reaches mip SYNC_STAGES+1 edges after it rises.
- Interrupt eligibility: irq_i = mstatus[3] & mie[i] & mip[i]. Priority among interrupts is 11 > 3 > 7.
- FSM states: IDLE, SAVE, MRET, REDIRECT.
- IDLE selection, applied at the edge:
  - exc_valid has highest priority. Capture mepc = {exc_pc[31:2], 2'b00}, mcause = {1'b0, 26'b0, exc_cause}, mbadaddr = exc_tval. Go to SAVE.
  - Else mret_valid: go to MRET. mepc, mcause and mbadaddr are unchanged.
  - Else boundary and any eligible irq: capture mepc = {boundary_pc[31:2], 2'b00}, mcause = 0x8000_0000 | code, mbadaddr = 0. Go to SAVE.
  - Else stay in IDLE.
- SAVE, exactly one cycle:
  - mstatus_we = 1.
  - mstatus_wdata = mstatus with bit7 = mstatus[3], bit3 = 0, bits[12:11] = 2'b11.
  - exc_ack = 1 only if the trap was an exception; interrupts produce no ack.
  - redirect_pc is loaded at the exit edge. If mtvec[1:0] == 1 and mcause[31] is set, the target is {mtvec[31:2], 2'b00} + 4*code. Otherwise the target is {mtvec[31:2], 2'b00`}; modes 2 and 3 behave as direct.
  - Go to REDIRECT.
- MRET, exactly one cycle:
  - mstatus_we = 1, mret_ack = 1.
  - mstatus_wdata = mstatus with bit3 = mstatus[7], bit7 = 1, bits[12:11] = 2'b11.
  - redirect_pc is loaded with mepc. Go to REDIRECT.
- REDIRECT:
  - redirect_valid = 1, with redirect_pc stable.
  - Return to IDLE on the edge where redirect_ready = 1. If ready is low, hold indefinitely.
- Latency: a request sampled at edge N gives ack/we high during cycle N+1 and redirect_valid high from cycle N+2. Minimum round trip is 3 cycles.
- Requests arriving while busy are not sampled. The core must hold exc_valid and mret_valid.
- If exc_valid and mret_valid are high together, the exception wins and MRET stays pending.
- mstatus_wdata is 0 whenever mstatus_we = 0.

Test Plan:
- Reset mid-REDIRECT: assert resetn -> redirect_valid, busy, mepc and mip are all 0 in the same cycle, before the next clock edge.
- Exception: exc_valid, cause 2, exc_pc 0x0000_1006, tval 0xDEAD_BEEF, mtvec 0x0000_0100, mstatus 0x08, with redirect_ready held high. Required response:
  - mepc = 0x1004, mcause = 2, mbadaddr = 0xDEAD_BEEF.
  - exc_ack and mstatus_we high with mstatus_wdata 0x1880 at cycle N+1.
  - redirect_pc = 0x100 at cycle N+2.
- Vectored timer interrupt: mtvec 0x0000_0201, mie 0x80, mstatus 0x08, mtip = 1, boundary_pc 0x400. Required response: mcause 0x8000_0007, mepc 0x400, mbadaddr 0, redirect_pc 0x21C, exc_ack never asserted.
- Priority and masking:
  - meip, msip and mtip all pending with all enabled -> mcause 0x8000_000B.
  - With mstatus 0x00 -> no trap, mip still 0x888.
- MRET: mepc 0x1004, mstatus 0x1880 -> mret_ack high, mstatus_wdata 0x1888, redirect_pc 0x1004.
- Backpressure and simultaneous requests:
  - exc_valid and mret_valid together, with redirect_ready low for 5 cycles -> redirect_valid held 5 cycles, busy high throughout.
  - MRET is taken only after returning to IDLE.
